autenticador_sequencial: RTL and testbench
==========================================

# autenticador_sequencial

Sequential, parametrised successor of the combinational authentication comparator. Accepts a (user, password) pair through a valid/ready handshake and scans a table of N_LEVELS credential entries, one per cycle. Reports the matching access level as a one-hot vector, plus granted or denied. After MAX_TRIES consecutive failures it locks out new requests for LOCK_CYCLES cycles; it sits between the input switch/debounce logic and the display/actuator logic.

## Interface
- ID_W, 3: user-identifier width.
- CODE_W, 3: password width.
- N_LEVELS, 3: table entries and access levels; entry i grants level i; must be ≥1.
- MAX_TRIES, 3: consecutive failures that trigger lockout; must be ≥1.
- LOCK_CYCLES, 8: lockout duration in cycles; must be ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- usuario  in  ID_W  user id; sampled on handshake.
- senha  in  CODE_W  password; sampled on handshake.
- res_valid  out  1  one-cycle result pulse.
- aut  out  N_LEVELS  one-hot granted level; all zeros on deny. Held until the next result.
- negado  out  1  deny flag; held with aut.
- bloqueado  out  1  high during lockout.
- prog_we, prog_idx [$clog2(N_LEVELS) or 1], prog_id [ID_W], prog_code [CODE_W]  in  table write port; present only with AUT_PROG_EN.

## Operation
- **States:** IDLE, CHECK, RESULT, LOCKED.
- **IDLE.** The handshake (req_valid & req_ready) captures usuario and senha, clears the match register and the index, and moves to CHECK.
- **CHECK.** Compares entry[idx] against the captured pair, one entry per cycle, for idx = 0 to N_LEVELS-1.
  - The scan always covers the full table; there is no early exit.
  - On multiple matches, the lowest index wins.
  - After idx = N_LEVELS-1, go to RESULT.
- **RESULT.** Asserts res_valid for one cycle and updates aut and negado.
  - On a match: aut = 1<<idx, negado = 0, failure counter cleared, go to IDLE.
  - On no match: aut = 0, negado = 1, failure counter incremented.
  - If the counter reaches MAX_TRIES: clear the counter, load the lock counter with LOCK_CYCLES, go to LOCKED. Otherwise go to IDLE.
- **LOCKED.** bloqueado = 1 and req_ready = 0. The lock counter decrements each cycle; on reaching 1 the FSM returns to IDLE on the next edge.
- **Counter widths.** The failure counter is $clog2(MAX_TRIES+1) bits and saturates at MAX_TRIES. The lock counter is $clog2(LOCK_CYCLES+1) bits. There is no wrap.
- **Reset.** Has priority at any point, including mid-CHECK or LOCKED, and aborts any request in progress without producing a res_valid.
  - Goes to IDLE.
  - Outputs: aut = 0, negado = 0, res_valid = 0, bloqueado = 0, req_ready = 1 on the cycle after reset deasserts.
  - Counters cleared; table loaded with package defaults.

## Timing
- **Latency.** A handshake at edge t produces res_valid high in the cycle after edge t+N_LEVELS+1, i.e. N_LEVELS+2 cycles from acceptance.
- **Back-to-back.** The next handshake is possible in the cycle after res_valid.
- **Lockout length.** bloqueado is high for exactly LOCK_CYCLES cycles. The first cycle is the one following the RESULT cycle.
- **Table writes.** Take effect at the edge where prog_we is high, and are accepted only in IDLE or LOCKED; writes in any other state are ignored.
- **Write and request together in IDLE.** Both are accepted, and the scan sees the new value.

## Configuration
- **AUT_PROG_EN defined:** the prog_* ports exist and the table is a register array, reset to the defaults.
- **AUT_PROG_EN undefined:** the prog_* ports are absent and the table is the constant default array from the package. Behaviour is otherwise identical.

## Structure
- **Package autenticacao_pkg holds:**
  - the state enum (IDLE, CHECK, RESULT, LOCKED);
  - the credential struct {id, code};
  - the default table:
    - entry0 = {3'b001, 3'b101};
    - entry1 = {3'b010, 3'b110};
    - entry2 = {3'b100, 3'b011}.
  - Extra entries beyond the default table are zero.
- **Sub-module comparador_entrada:** one natural combinational sub-module that compares a captured pair against one entry and returns equality. It is instantiated once and muxed by idx.

## Test plan
- Reset, then request usuario=3'b010, senha=3'b110 → res_valid 5 cycles after acceptance, aut=3'b010, negado=0.
- Request 3'b001/3'b000 → aut=3'b000, negado=1; a following 3'b100/3'b011 → aut=3'b100, failure counter cleared.
- Three consecutive bad requests → bloqueado high for exactly 8 cycles and req_ready=0 throughout; a request held during lockout is accepted on the first IDLE cycle.
- rst pulsed during CHECK → no res_valid; aut=0, req_ready=1 on the next cycle; a new request completes normally.
- AUT_PROG_EN: write idx=0, id=3'b111, code=3'b111 in IDLE → request 3'b111/3'b111 gives aut=3'b001, and the old 3'b001/3'b101 is denied. A prog_we during CHECK is ignored.
- Duplicate credential in entries 1 and 2 (via prog) → aut=3'b010, i.e. the lowest index wins.

Source files
------------

// File: rtl/autenticacao_pkg.sv
// Shared types for the sequential authenticator: FSM states, credential record
// and the default credential table loaded at reset.
package autenticacao_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESULT = 2'd2,
        LOCKED = 2'd3
    } estado_t;

    localparam int CRED_ID_W   = 3;
    localparam int CRED_CODE_W = 3;

    typedef struct packed {
        logic [CRED_ID_W-1:0]   id;
        logic [CRED_CODE_W-1:0] code;
    } credencial_t;

    // Entries past the third are deliberately all-zero credentials.
    function automatic credencial_t entrada_padrao(input int unsigned i);
        credencial_t c;
        case (i)
            32'd0:   c = '{id: 3'b001, code: 3'b101};
            32'd1:   c = '{id: 3'b010, code: 3'b110};
            32'd2:   c = '{id: 3'b100, code: 3'b011};
            default: c = '{id: 3'b000, code: 3'b000};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/comparador_entrada.sv
// Combinational equality check of a captured (user, password) pair against one
// table entry.
module comparador_entrada #(
    parameter int ID_W   = 3,
    parameter int CODE_W = 3
) (
    input  logic [ID_W-1:0]   cap_id,
    input  logic [CODE_W-1:0] cap_code,
    input  logic [ID_W-1:0]   entry_id,
    input  logic [CODE_W-1:0] entry_code,
    output logic              igual
);

    assign igual = (cap_id == entry_id) && (cap_code == entry_code);

endmodule

// File: rtl/autenticador_sequencial.sv
// Sequential authenticator: full-table scan, one entry per cycle, one-hot grant
// and lockout after repeated failures. Optional macro AUT_PROG_EN adds a
// writable credential table with its prog_* port.
module autenticador_sequencial
    import autenticacao_pkg::*;
#(
    parameter int ID_W        = 3,
    parameter int CODE_W      = 3,
    parameter int N_LEVELS    = 3,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_W-1:0]     usuario,
    input  logic [CODE_W-1:0]   senha,
    output logic                res_valid,
    output logic [N_LEVELS-1:0] aut,
    output logic                negado,
    output logic                bloqueado
`ifdef AUT_PROG_EN
    ,
    input  logic                prog_we,
    input  logic [((N_LEVELS > 1) ? $clog2(N_LEVELS) : 1)-1:0] prog_idx,
    input  logic [ID_W-1:0]     prog_id,
    input  logic [CODE_W-1:0]   prog_code
`endif
);

    localparam int IDX_W  = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    function automatic logic [ID_W-1:0] id_padrao(input int unsigned i);
        credencial_t c;
        c = entrada_padrao(i);
        return ID_W'(c.id);
    endfunction

    function automatic logic [CODE_W-1:0] code_padrao(input int unsigned i);
        credencial_t c;
        c = entrada_padrao(i);
        return CODE_W'(c.code);
    endfunction

    estado_t             state_r, state_next_s;
    logic [IDX_W-1:0]    idx_r, match_idx_r;
    logic                found_r;
    logic [ID_W-1:0]     cap_id_r;
    logic [CODE_W-1:0]   cap_code_r;
    logic [FAIL_W-1:0]   fail_cnt_r;
    logic [LOCK_W-1:0]   lock_cnt_r;
    logic                res_valid_r, negado_r, bloqueado_r, req_ready_r;
    logic [N_LEVELS-1:0] aut_r;

    logic [ID_W-1:0]     tab_id_s   [N_LEVELS];
    logic [CODE_W-1:0]   tab_code_s [N_LEVELS];
    logic                igual_s, idx_last_s, lock_trig_s;

`ifdef AUT_PROG_EN
    logic [ID_W-1:0]     tab_id_r   [N_LEVELS];
    logic [CODE_W-1:0]   tab_code_r [N_LEVELS];
    logic                prog_ok_s;

    // Writes only land while no scan is using the table.
    assign prog_ok_s = prog_we && ((state_r == IDLE) || (state_r == LOCKED))
                       && ({{(32-IDX_W){1'b0}}, prog_idx} < 32'(N_LEVELS));

    // Credential table register file, reloaded with defaults on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEVELS; i++) begin
                tab_id_r[i]   <= id_padrao(i);
                tab_code_r[i] <= code_padrao(i);
            end
        end else if (prog_ok_s) begin
            tab_id_r[prog_idx]   <= prog_id;
            tab_code_r[prog_idx] <= prog_code;
        end
    end

    // Expose the register file to the scan mux.
    always_comb begin
        tab_id_s   = tab_id_r;
        tab_code_s = tab_code_r;
    end
`else
    // Constant default table.
    always_comb begin
        for (int i = 0; i < N_LEVELS; i++) begin
            tab_id_s[i]   = id_padrao(i);
            tab_code_s[i] = code_padrao(i);
        end
    end
`endif

    comparador_entrada #(
        .ID_W   (ID_W),
        .CODE_W (CODE_W)
    ) u_comparador (
        .cap_id     (cap_id_r),
        .cap_code   (cap_code_r),
        .entry_id   (tab_id_s[idx_r]),
        .entry_code (tab_code_s[idx_r]),
        .igual      (igual_s)
    );

    assign idx_last_s  = (idx_r == IDX_W'(N_LEVELS - 1));
    assign lock_trig_s = !found_r && (fail_cnt_r >= FAIL_W'(MAX_TRIES - 1));

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_next_s = CHECK;
                else           state_next_s = IDLE;
            end
            CHECK: begin
                if (idx_last_s) state_next_s = RESULT;
                else            state_next_s = CHECK;
            end
            RESULT: begin
                if (lock_trig_s) state_next_s = LOCKED;
                else             state_next_s = IDLE;
            end
            LOCKED: begin
                if (lock_cnt_r <= LOCK_W'(1)) state_next_s = IDLE;
                else                          state_next_s = LOCKED;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            match_idx_r <= '0;
            found_r     <= 1'b0;
            cap_id_r    <= '0;
            cap_code_r  <= '0;
            fail_cnt_r  <= '0;
            lock_cnt_r  <= '0;
            res_valid_r <= 1'b0;
            aut_r       <= '0;
            negado_r    <= 1'b0;
            bloqueado_r <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            res_valid_r <= (state_r == RESULT);
            req_ready_r <= (state_next_s == IDLE);
            bloqueado_r <= (state_next_s == LOCKED);
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        cap_id_r   <= usuario;
                        cap_code_r <= senha;
                        found_r    <= 1'b0;
                        idx_r      <= '0;
                    end
                end
                CHECK: begin
                    // First hit is kept, so the lowest index wins on duplicates.
                    if (igual_s && !found_r) begin
                        found_r     <= 1'b1;
                        match_idx_r <= idx_r;
                    end
                    if (!idx_last_s) idx_r <= idx_r + IDX_W'(1);
                end
                RESULT: begin
                    if (found_r) begin
                        aut_r      <= N_LEVELS'(1'b1) << match_idx_r;
                        negado_r   <= 1'b0;
                        fail_cnt_r <= '0;
                    end else begin
                        aut_r    <= '0;
                        negado_r <= 1'b1;
                        if (lock_trig_s) begin
                            fail_cnt_r <= '0;
                            lock_cnt_r <= LOCK_W'(LOCK_CYCLES);
                        end else if (fail_cnt_r < FAIL_W'(MAX_TRIES)) begin
                            fail_cnt_r <= fail_cnt_r + FAIL_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (lock_cnt_r > LOCK_W'(1)) lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign res_valid = res_valid_r;
    assign aut       = aut_r;
    assign negado    = negado_r;
    assign bloqueado = bloqueado_r;

endmodule

// File: tb/tb_autenticador_sequencial.sv
// Directed self-checking bench for autenticador_sequencial; programming tests
// run only when AUT_PROG_EN is defined.
module tb_autenticador_sequencial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] usuario = 3'b000;
    logic [2:0] senha = 3'b000;
    logic       res_valid;
    logic [2:0] aut;
    logic       negado;
    logic       bloqueado;
    logic       prog_we = 1'b0;
    logic [1:0] prog_idx = 2'd0;
    logic [2:0] prog_id = 3'b000;
    logic [2:0] prog_code = 3'b000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    autenticador_sequencial dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .usuario   (usuario),
        .senha     (senha),
        .res_valid (res_valid),
        .aut       (aut),
        .negado    (negado),
        .bloqueado (bloqueado)
`ifdef AUT_PROG_EN
        ,
        .prog_we   (prog_we),
        .prog_idx  (prog_idx),
        .prog_id   (prog_id),
        .prog_code (prog_code)
`endif
    );

    // Issues one request and returns at the negedge where res_valid is seen.
    task automatic do_req(input logic [2:0] id, input logic [2:0] code,
                          output int lat, output logic [2:0] a, output logic n);
        bit rdy;
        rdy = 1'b0;
        req_valid = 1'b1;
        usuario   = id;
        senha     = code;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                rdy = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!rdy) begin
            n_err++;
            $display("FAIL req_ready_wait: got never-ready want ready within 50 cycles");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        a = aut;
        n = negado;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (aut !== 3'b000) begin n_err++; $display("FAIL reset_aut: got %b want 000", aut); end
        n_cmp++; if (negado !== 1'b0) begin n_err++; $display("FAIL reset_negado: got %b want 0", negado); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (bloqueado !== 1'b0) begin n_err++; $display("FAIL reset_bloqueado: got %b want 0", bloqueado); end
    endtask

    task automatic test_grant();
        int lat; logic [2:0] a; logic n;
        do_req(3'b010, 3'b110, lat, a, n);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL grant_latency: got %0d want 5", lat); end
        n_cmp++; if (a !== 3'b010) begin n_err++; $display("FAIL grant_aut: got %b want 010", a); end
        n_cmp++; if (n !== 1'b0) begin n_err++; $display("FAIL grant_negado: got %b want 0", n); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL grant_pulse: got %b want 0", res_valid); end
        n_cmp++; if (aut !== 3'b010) begin n_err++; $display("FAIL grant_hold: got %b want 010", aut); end
    endtask

    task automatic test_deny_then_grant();
        int lat; logic [2:0] a; logic n;
        do_req(3'b001, 3'b000, lat, a, n);
        n_cmp++; if (a !== 3'b000) begin n_err++; $display("FAIL deny_aut: got %b want 000", a); end
        n_cmp++; if (n !== 1'b1) begin n_err++; $display("FAIL deny_negado: got %b want 1", n); end
        do_req(3'b100, 3'b011, lat, a, n);
        n_cmp++; if (a !== 3'b100) begin n_err++; $display("FAIL grant2_aut: got %b want 100", a); end
        n_cmp++; if (n !== 1'b0) begin n_err++; $display("FAIL grant2_negado: got %b want 0", n); end
    endtask

    task automatic test_lockout();
        int lat; int lock_len; logic [2:0] a; logic n; bit ready_seen;
        do_req(3'b111, 3'b111, lat, a, n);
        do_req(3'b000, 3'b001, lat, a, n);
        // Counter was cleared by the previous grant, so two failures must not lock.
        n_cmp++; if (bloqueado !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", bloqueado); end
        do_req(3'b011, 3'b011, lat, a, n);
        n_cmp++; if (n !== 1'b1) begin n_err++; $display("FAIL lock_third_negado: got %b want 1", n); end
        n_cmp++; if (bloqueado !== 1'b1) begin n_err++; $display("FAIL lock_start: got %b want 1", bloqueado); end
        req_valid = 1'b1;
        usuario   = 3'b010;
        senha     = 3'b110;
        lock_len   = bloqueado ? 1 : 0;
        ready_seen = req_ready;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bloqueado) break;
            lock_len++;
            if (req_ready) ready_seen = 1'b1;
        end
        n_cmp++; if (lock_len !== 8) begin n_err++; $display("FAIL lock_length: got %0d want 8", lock_len); end
        n_cmp++; if (ready_seen !== 1'b0) begin n_err++; $display("FAIL lock_ready_low: got %b want 0", ready_seen); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL lock_exit_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL held_req_latency: got %0d want 5", lat); end
        n_cmp++; if (aut !== 3'b010) begin n_err++; $display("FAIL held_req_aut: got %b want 010", aut); end
    endtask

    task automatic test_reset_mid_check();
        int lat; logic [2:0] a; logic n; bit saw_rv;
        req_valid = 1'b1;
        usuario   = 3'b100;
        senha     = 3'b011;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        n_cmp++; if (aut !== 3'b000) begin n_err++; $display("FAIL midrst_aut: got %b want 000", aut); end
        n_cmp++; if (negado !== 1'b0) begin n_err++; $display("FAIL midrst_negado: got %b want 0", negado); end
        saw_rv = res_valid;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) saw_rv = 1'b1;
        end
        n_cmp++; if (saw_rv !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got %b want 0", saw_rv); end
        do_req(3'b001, 3'b101, lat, a, n);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL postrst_latency: got %0d want 5", lat); end
        n_cmp++; if (a !== 3'b001) begin n_err++; $display("FAIL postrst_aut: got %b want 001", a); end
    endtask

`ifdef AUT_PROG_EN
    task automatic prog_write(input logic [1:0] idx, input logic [2:0] id, input logic [2:0] code);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_idx  = idx;
        prog_id   = id;
        prog_code = code;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic test_prog();
        int lat; logic [2:0] a; logic n;
        prog_write(2'd0, 3'b111, 3'b111);
        do_req(3'b111, 3'b111, lat, a, n);
        n_cmp++; if (a !== 3'b001) begin n_err++; $display("FAIL prog_new_aut: got %b want 001", a); end
        do_req(3'b001, 3'b101, lat, a, n);
        n_cmp++; if (n !== 1'b1) begin n_err++; $display("FAIL prog_old_denied: got %b want 1", n); end
        // A write during CHECK must not disturb entry 1.
        req_valid = 1'b1;
        usuario   = 3'b010;
        senha     = 3'b110;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        prog_we   = 1'b1;
        prog_idx  = 2'd1;
        prog_id   = 3'b000;
        prog_code = 3'b000;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) prog_we = 1'b0;
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++; if (aut !== 3'b010) begin n_err++; $display("FAIL prog_check_ignored: got %b want 010", aut); end
        prog_write(2'd1, 3'b101, 3'b010);
        prog_write(2'd2, 3'b101, 3'b010);
        do_req(3'b101, 3'b010, lat, a, n);
        n_cmp++; if (a !== 3'b010) begin n_err++; $display("FAIL prog_lowest_wins: got %b want 010", a); end
    endtask
`endif

    initial begin
        test_reset();
        test_grant();
        test_deny_then_grant();
        test_lockout();
        test_reset_mid_check();
`ifdef AUT_PROG_EN
        test_prog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
